// File: rtl/pipe_stage_reg.sv
// Two-entry inter-stage register (main + skid) with flush/freeze; one falling edge in-to-out, 1 entry/cycle.
// in_ready depends only on state, flush and freeze (never out_ready); downstream stalls are absorbed by the skid entry.
module pipe_stage_reg #(
    parameter int CTRL_W            = 12,
    parameter int DATA_W            = 128,
    parameter bit FLUSH_CLEARS_DATA = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                in_fire, out_fire;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_comb begin
        in_ready  = ~flush & ~freeze & (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY) & ~freeze;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        out_ctrl  = out_valid ? m_ctrl_q : '0;
        out_data  = m_data_q;
        stall_cnt = stall_cnt_q;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (FLUSH_CLEARS_DATA) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (in_fire) begin
                        state_d  = ST_FULL;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_fire) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Falling-edge update keeps this stage aligned with the rest of the pipeline registers.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            m_ctrl_q    <= '0;
            m_data_q    <= '0;
            s_ctrl_q    <= '0;
            s_data_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            s_ctrl_q    <= s_ctrl_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: dut0 uses default parameters, dut1 keeps data on flush and has a 4-bit stall counter.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst, flush, freeze, in_valid, out_ready, cnt_clr;
    logic [11:0]  in_ctrl;
    logic [127:0] in_data;

    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [11:0]  out_ctrl0, out_ctrl1;
    logic [127:0] out_data0, out_data1;
    logic [1:0]   occ0, occ1;
    logic [15:0]  stall0;
    logic [3:0]   stall1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0), .cnt_clr(cnt_clr), .stall_cnt(stall0)
    );

    pipe_stage_reg #(.FLUSH_CLEARS_DATA(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1), .cnt_clr(cnt_clr), .stall_cnt(stall1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // one active (falling) edge, then settle
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic [127:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; cnt_clr = 1'b0;
        out_ready = 1'b0; drive(1'b0, 12'h0, 128'h0);
        cyc(); cyc();
        rst = 1'b0; #1;
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_ctrl", out_ctrl0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_stall", stall0, 0);

        // single transfer
        out_ready = 1'b1;
        drive(1'b1, 12'h5A5, 128'h1234);
        cyc();
        drive(1'b0, 12'h0, 128'h0); #1;
        chk("t1_valid", out_valid0, 1);
        chk("t1_ctrl", out_ctrl0, 12'h5A5);
        chk("t1_data", out_data0, 128'h1234);
        chk("t1_occ1", occ0, 1);
        cyc();
        chk("t1_occ0", occ0, 0);
        chk("t1_bubble_ctrl", out_ctrl0, 0);

        // back-to-back stream of 8
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, 12'(i + 1), 128'(32'h100 + i * 32'h11));
            else       drive(1'b0, 12'h0, 128'h0);
            #1;
            if (i < 8) chk("s_in_ready", in_ready0, 1);
            if (i > 0) begin
                chk("s_valid", out_valid0, 1);
                chk("s_ctrl", out_ctrl0, 12'(i));
                chk("s_data", out_data0, 128'(32'h100 + (i - 1) * 32'h11));
            end
            cyc();
        end
        chk("s_drained", occ0, 0);
        chk("s_stall", stall0, 0);

        // fill skid with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 12'h0A1, 128'hAAAA); cyc();
        drive(1'b1, 12'h0B1, 128'hBBBB); #1;
        chk("f_in_ready_one", in_ready0, 1);
        cyc();
        drive(1'b1, 12'h0C1, 128'hCCCC); #1;
        chk("f_in_ready_full", in_ready0, 0);
        chk("f_occ2", occ0, 2);
        chk("f_head_a", out_ctrl0, 12'h0A1);
        cyc(); cyc();
        chk("f_hold_occ", occ0, 2);
        chk("f_stall3", stall0, 3);
        out_ready = 1'b1; #1;
        chk("f_out_a", out_data0, 128'hAAAA);
        cyc();
        chk("f_out_b", out_ctrl0, 12'h0B1);
        chk("f_in_ready_again", in_ready0, 1);
        cyc();
        chk("f_out_c", out_data0, 128'hCCCC);
        drive(1'b0, 12'h0, 128'h0);
        cyc();
        chk("f_empty", occ0, 0);
        chk("f_stall_final", stall0, 3);

        // flush from FULL
        out_ready = 1'b0;
        drive(1'b1, 12'h0D1, 128'hD0D0); cyc();
        drive(1'b1, 12'h0E1, 128'hE0E0); cyc();
        drive(1'b0, 12'h0, 128'h0);
        chk("fl_full", occ0, 2);
        flush = 1'b1; #1;
        chk("fl_in_ready", in_ready0, 0);
        chk("fl_out_valid_during", out_valid0, 1);
        cyc();
        flush = 1'b0; #1;
        chk("fl_occ", occ0, 0);
        chk("fl_valid", out_valid0, 0);
        chk("fl_ctrl", out_ctrl0, 0);
        chk("fl_data_cleared", out_data0, 0);
        chk("fl_data_kept", out_data1, 128'hD0D0);
        chk("fl_ctrl_kept_dut", out_ctrl1, 0);
        chk("fl_stall", stall0, 5);

        // freeze with flush in its 2nd cycle
        out_ready = 1'b1;
        drive(1'b1, 12'h0F1, 128'hF0F0); cyc();
        drive(1'b0, 12'h0, 128'h0);
        freeze = 1'b1; #1;
        chk("fz_valid", out_valid0, 0);
        chk("fz_in_ready", in_ready0, 0);
        chk("fz_ctrl", out_ctrl0, 0);
        chk("fz_data", out_data0, 128'hF0F0);
        cyc();
        chk("fz_occ1", occ0, 1);
        flush = 1'b1; cyc();
        flush = 1'b0;
        chk("fz_flush_wins", occ0, 0);
        cyc();
        freeze = 1'b0; #1;
        chk("fz_after_valid", out_valid0, 0);

        // freeze without flush: M held, new input refused
        drive(1'b1, 12'h0A7, 128'hABCD); cyc();
        drive(1'b1, 12'h0EE, 128'hEEEE);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fz2_valid", out_valid0, 0);
            chk("fz2_in_ready", in_ready0, 0);
            cyc();
            chk("fz2_occ", occ0, 1);
            chk("fz2_data", out_data0, 128'hABCD);
        end
        freeze = 1'b0;
        drive(1'b0, 12'h0, 128'h0); #1;
        chk("fz2_release_ctrl", out_ctrl0, 12'h0A7);
        cyc();
        chk("fz2_empty", occ0, 0);
        chk("fz2_stall", stall0, 5);

        // counter saturation and clear
        out_ready = 1'b0;
        drive(1'b1, 12'h011, 128'h1111); cyc();
        drive(1'b0, 12'h0, 128'h0);
        repeat (20) cyc();
        chk("sat_cnt4", stall1, 4'd15);
        chk("sat_cnt16", stall0, 16'd25);
        cnt_clr = 1'b1; cyc();
        cnt_clr = 1'b0;
        chk("clr_cnt4", stall1, 0);
        chk("clr_cnt16", stall0, 0);
        cyc();
        chk("clr_resume", stall0, 1);

        // reset mid-transfer
        drive(1'b1, 12'h022, 128'h2222); cyc();
        drive(1'b0, 12'h0, 128'h0);
        chk("rst2_full", occ0, 2);
        rst = 1'b1; cyc();
        rst = 1'b0; #1;
        chk("rst2_occ", occ0, 0);
        chk("rst2_data", out_data1, 0);
        chk("rst2_stall", stall0, 0);
        chk("rst2_in_ready", in_ready0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the pipelined CPU, generalising the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control word and a data word, with valid/ready handshake, a 2-entry skid buffer, flush, freeze and a stall-cycle performance counter.
- Instantiated between any two stages. The control word holds RegWrite, MemWrite, MemRead and similar bits; the data word holds instruction, PC+4, ALU result and similar fields.

Parameters:
- CTRL_W, 12, width of the control word; zeroed on every bubble.
- DATA_W, 128, width of the data word (instruction, PC+4, ALU result, store data).
- FLUSH_CLEARS_DATA, 1, 1 = flush also zeroes stored data words; 0 = data words keep their values on flush.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the falling edge, matching the other pipeline registers.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all held entries (branch/exception squash).
- freeze  input  1  hold all state; legacy stall semantics.
- in_valid  input  1  upstream stage presents an entry.
- in_ready  output  1  this stage can accept.
- in_ctrl  input  CTRL_W  upstream control word.
- in_data  input  DATA_W  upstream data word.
- out_valid  output  1  entry available to downstream.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  control word of head entry; 0 when out_valid=0.
- out_data  output  DATA_W  data word of head entry.
- occupancy  output  2  number of held entries, 0..2.
- cnt_clr  input  1  clear the stall counter.
- stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. State machine: EMPTY (occupancy 0), ONE (M valid, occupancy 1), FULL (M and S valid, occupancy 2).
- Handshake signals:
  - in_ready = ~flush & ~freeze & (state != FULL).
  - out_valid = (state != EMPTY) & ~freeze.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Priority: rst > flush > freeze > handshake.
- Transitions on a falling edge with no rst, flush or freeze:
  - EMPTY + in_fire -> ONE, M <= in.
  - ONE + in_fire + out_fire -> ONE, M <= in (back-to-back, no bubble).
  - ONE + in_fire + !out_fire -> FULL, S <= in.
  - ONE + !in_fire + out_fire -> EMPTY.
  - FULL + out_fire -> ONE, M <= S. in_fire is impossible in FULL.
  - Any other combination holds.
- Latency: one falling edge from in_fire to out_valid. Sustained throughput is 1 entry per cycle. in_ready depends only on state, flush and freeze, never on out_ready, so there is no combinational ready path.
- Flush:
  - Next edge -> EMPTY; M and S control words <= 0.
  - Data words <= 0 only if FLUSH_CLEARS_DATA=1.
  - Any out_fire in the same cycle is still valid for downstream.
  - in_ready is 0 during flush, so no input is lost silently.
  - Flush overrides freeze (unlike legacy, where stall masked flush).
- Freeze: all storage and state hold. in_ready=0 and out_valid=0; out_ctrl reads 0 and out_data keeps its value.
- rst: state EMPTY, M/S ctrl and data = 0, stall_cnt = 0.
  - Outputs after reset: in_ready=1 once rst deasserts, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - rst mid-transfer discards both entries.
- out_ctrl is forced to 0 whenever out_valid=0 (bubble guarantee). out_data is not forced.
- stall_cnt:
  - Increments on each edge where out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr zeroes it and has priority over the increment.
  - Unaffected by flush and freeze.

Test Plan:
- Reset then in_valid=1 with ctrl=0x5A5 and data=0x1234 for one cycle, out_ready=1 -> out_valid=1 one edge later with ctrl 0x5A5 and data 0x1234; occupancy=1, then 0.
- Stream 8 entries with in_valid and out_ready held at 1 -> 8 consecutive out_valid cycles with no gap, in order; in_ready stays 1.
- out_ready=0 while pushing A, B, C -> A in M, B in S, occupancy=2, in_ready=0, C is held by upstream. Raise out_ready -> outputs A, B, C in order; stall_cnt equals the number of cycles with out_valid=1 and out_ready=0.
- FULL, then flush for one cycle -> occupancy=0, out_valid=0, out_ctrl=0; out_data=0 with FLUSH_CLEARS_DATA=1, and the old value held with FLUSH_CLEARS_DATA=0.
- freeze=1 for 3 cycles while in state ONE, with flush asserted in the 2nd cycle -> flush wins and the stage is EMPTY after that edge. Without flush, M is unchanged, out_valid=0 and in_ready=0 throughout.
- CNT_W=4 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15; cnt_clr together with a stall cycle -> 0.
